operand_bypass: RTL
===================

# operand_bypass

Parametrised operand forwarding unit for the pipelined MIPS core. It tracks in-flight register writers in a STAGES-deep scoreboard and selects each of two source operands (rs, rt) from the register file or the youngest matching downstream stage result. It raises a load-use stall when a matching load has not yet produced data. It sits between ID and EX and generalises the fixed three-input forwarding mux.

## Interface
- WIDTH, 32, operand/result data width
- STAGES, 3, tracked pipeline stages after ID (stage 0 = EX output, STAGES-1 = oldest before RF write)
- REG_AW, 5, register address width; register 0 is never forwarded
- LOAD_STAGE, 1, first stage index at which load data is valid in stage_data

- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global freeze; scoreboard does not advance
- flush  in  1  current ID instruction is killed; enters scoreboard as a bubble
- issue_valid  in  1  ID holds a real instruction
- issue_we  in  1  ID instruction writes a register
- issue_is_load  in  1  ID instruction is a load
- issue_dest  in  REG_AW  destination register of ID instruction
- rs_addr, rt_addr  in  REG_AW  source registers of ID instruction
- rs_rf_data, rt_rf_data  in  WIDTH  register file read data
- stage_data  in  STAGES*WIDTH  result of stage k at bits [k*WIDTH +: WIDTH]
- rs_out, rt_out  out  WIDTH  selected operands
- rs_sel, rt_sel  out  $clog2(STAGES+1)  0 = RF, k+1 = stage k
- stall  out  1  load-use hazard; ID must hold

## Operation
- Scoreboard entry e[k] = {valid, we, is_load, dest}.
- Each entry matches an operand when valid & we & dest==addr & addr!=0.
- The lowest k match wins (youngest). With no match: sel=0 and out=rf_data.
- Matched entry with is_load=1 and k<LOAD_STAGE sets stall=1 for that operand. sel=0 during stall; out value is don't-care.
- stall = rs_stall | rt_stall, qualified by issue_valid & ~flush.
- Advance when hold=0: e[k]<=e[k-1] for k>=1; e[0]<=issue entry.
  - The issue entry is valid only if issue_valid & ~stall & ~flush; otherwise a bubble (valid=0).
- e[STAGES-1] drops off at the same edge the datapath writes the RF. The RF is write-first, so the next-cycle read sees the value.
- hold=1 freezes all entries, regardless of stall or flush.

## Timing
- Select, out and stall are combinational from the registered scoreboard and current inputs; there is zero added latency.
- Scoreboard update latency: 1 cycle.
- Reset: all entries valid=0, so stall=0, rs_sel=rt_sel=0, rs_out/rt_out follow rf_data, and the stats counters are 0.
- A load-use distance of d stages (d<LOAD_STAGE) stalls for exactly LOAD_STAGE-d cycles when hold=0.
- Simultaneous stall and flush: flush wins. stall is deasserted and a bubble is inserted.
- Reset asserted mid-operation clears all in-flight tracking immediately (asynchronous).

## Configuration
- BYPASS_STATS_EN defined:
  - Adds outputs fwd_count[31:0] and stall_count[31:0].
  - fwd_count increments on cycles with hold=0, issue_valid, ~stall and any sel!=0.
  - stall_count increments on cycles with hold=0 and stall=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- BYPASS_STATS_EN undefined: no counters and no ports; the block is otherwise identical.

## Structure
- Package bypass_pkg holds the following:
  - SEL_RF = 0 constant.
  - Scoreboard entry struct typedef.
  - Default REG_AW.
- Sub-module bypass_match is instantiated twice (rs, rt). It does the priority match over the entries and returns sel, the load stall, and the muxed data.
- Top module operand_bypass holds the scoreboard registers, issue qualification, and the optional counters.

## Test plan
- Reset, then rs_addr=5 with rs_rf_data=32'h11 -> rs_out=32'h11, rs_sel=0, stall=0.
- Issue ALU writer of r5, next cycle rs_addr=5 with stage_data[0]=32'hAB -> rs_sel=1, rs_out=32'hAB.
- Writers of r5 in stages 0 and 1 (values 32'h1, 32'h2) -> rs_out=32'h1, i.e. the youngest wins.
- Issue load to r7, next cycle rt_addr=7 (LOAD_STAGE=1) -> stall=1 for one cycle. The following cycle gives rt_sel=2 and rt_out=stage_data[1].
- rs_addr=0 with an active writer of r0 -> rs_sel=0 and rs_out=rs_rf_data.
- Load-use stall with flush=1 in the same cycle -> stall=0 and a bubble enters. With hold=1 for 3 cycles, sel stays constant and the scoreboard is unchanged. With BYPASS_STATS_EN, stall_count does not increment.

Source files
------------

// File: rtl/bypass_pkg.sv
// Shared types and constants for the operand forwarding unit.
// Default REG_AW and the scoreboard entry layout.
package bypass_pkg;

  localparam int REG_AW_DEFAULT = 5;
  localparam int SEL_RF         = 0;

  // Per-stage control flags; the destination register is kept in a separate
  // array because its width is a per-instance parameter.
  typedef struct packed {
    logic valid;
    logic we;
    logic is_load;
  } sb_entry_t;

endpackage

// File: rtl/bypass_match.sv
// Priority match of one source operand against the in-flight scoreboard.
// The youngest (lowest index) matching stage wins; an immature load reports a stall.
module bypass_match
  import bypass_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 3,
  parameter int REG_AW     = REG_AW_DEFAULT,
  parameter int LOAD_STAGE = 1,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic [STAGES-1:0]        ent_valid,
  input  logic [STAGES-1:0]        ent_we,
  input  logic [STAGES-1:0]        ent_load,
  input  logic [STAGES*REG_AW-1:0] ent_dest,
  input  logic [REG_AW-1:0]        addr,
  input  logic [WIDTH-1:0]         rf_data,
  input  logic [STAGES*WIDTH-1:0]  stage_data,
  output logic [SEL_W-1:0]         sel,
  output logic                     load_stall,
  output logic [WIDTH-1:0]         data
);

  logic [SEL_W-1:0] hit_sel_s;
  logic             hit_load_s;
  logic [WIDTH-1:0] hit_data_s;

  // Walk oldest to youngest so a younger match overrides an older one.
  always_comb begin
    hit_sel_s  = SEL_W'(SEL_RF);
    hit_load_s = 1'b0;
    hit_data_s = rf_data;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (ent_valid[k] && ent_we[k] && (addr != '0) &&
          (ent_dest[k*REG_AW +: REG_AW] == addr)) begin
        hit_sel_s  = SEL_W'(k + 1);
        hit_load_s = ent_load[k] && (k < LOAD_STAGE);
        hit_data_s = stage_data[k*WIDTH +: WIDTH];
      end else begin
        hit_sel_s  = hit_sel_s;
        hit_load_s = hit_load_s;
        hit_data_s = hit_data_s;
      end
    end
  end

  // A stalled operand falls back to the RF path; its value is not consumed.
  always_comb begin
    if (hit_load_s) begin
      sel        = SEL_W'(SEL_RF);
      load_stall = 1'b1;
      data       = rf_data;
    end else begin
      sel        = hit_sel_s;
      load_stall = 1'b0;
      data       = hit_data_s;
    end
  end

endmodule

// File: rtl/operand_bypass.sv
// Operand forwarding unit between ID and EX: scoreboard, issue qualification, stall.
// Optional statistics counters are enabled with `define BYPASS_STATS_EN.
module operand_bypass
  import bypass_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 3,
  parameter int REG_AW     = REG_AW_DEFAULT,
  parameter int LOAD_STAGE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hold,
  input  logic                          flush,
  input  logic                          issue_valid,
  input  logic                          issue_we,
  input  logic                          issue_is_load,
  input  logic [REG_AW-1:0]             issue_dest,
  input  logic [REG_AW-1:0]             rs_addr,
  input  logic [REG_AW-1:0]             rt_addr,
  input  logic [WIDTH-1:0]              rs_rf_data,
  input  logic [WIDTH-1:0]              rt_rf_data,
  input  logic [STAGES*WIDTH-1:0]       stage_data,
  output logic [WIDTH-1:0]              rs_out,
  output logic [WIDTH-1:0]              rt_out,
  output logic [$clog2(STAGES+1)-1:0]   rs_sel,
  output logic [$clog2(STAGES+1)-1:0]   rt_sel,
`ifdef BYPASS_STATS_EN
  output logic [31:0]                   fwd_count,
  output logic [31:0]                   stall_count,
`endif
  output logic                          stall
);

  localparam int SEL_W = $clog2(STAGES + 1);

  sb_entry_t [STAGES-1:0]             ent_q, ent_d;
  logic      [STAGES-1:0][REG_AW-1:0] dest_q, dest_d;
  logic      [STAGES-1:0]             ent_valid_s, ent_we_s, ent_load_s;
  logic      [STAGES*REG_AW-1:0]      dest_flat_s;
  logic                               rs_stall_s, rt_stall_s, stall_s;

  // Unpack the scoreboard into flat vectors for the match units.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ent_valid_s[k] = ent_q[k].valid;
      ent_we_s[k]    = ent_q[k].we;
      ent_load_s[k]  = ent_q[k].is_load;
    end
    dest_flat_s = dest_q;
  end

  bypass_match #(
    .WIDTH(WIDTH), .STAGES(STAGES), .REG_AW(REG_AW), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_match_rs (
    .ent_valid(ent_valid_s), .ent_we(ent_we_s), .ent_load(ent_load_s), .ent_dest(dest_flat_s),
    .addr(rs_addr), .rf_data(rs_rf_data), .stage_data(stage_data),
    .sel(rs_sel), .load_stall(rs_stall_s), .data(rs_out)
  );

  bypass_match #(
    .WIDTH(WIDTH), .STAGES(STAGES), .REG_AW(REG_AW), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_match_rt (
    .ent_valid(ent_valid_s), .ent_we(ent_we_s), .ent_load(ent_load_s), .ent_dest(dest_flat_s),
    .addr(rt_addr), .rf_data(rt_rf_data), .stage_data(stage_data),
    .sel(rt_sel), .load_stall(rt_stall_s), .data(rt_out)
  );

  // A flushed instruction never stalls; it simply becomes a bubble.
  assign stall_s = (rs_stall_s | rt_stall_s) & issue_valid & ~flush;
  assign stall   = stall_s;

  // Shift the scoreboard one stage unless frozen by hold.
  always_comb begin
    ent_d  = ent_q;
    dest_d = dest_q;
    if (!hold) begin
      ent_d[0].valid   = issue_valid & ~stall_s & ~flush;
      ent_d[0].we      = issue_we;
      ent_d[0].is_load = issue_is_load;
      dest_d[0]        = issue_dest;
      for (int k = 1; k < STAGES; k++) begin
        ent_d[k]  = ent_q[k-1];
        dest_d[k] = dest_q[k-1];
      end
    end else begin
      ent_d  = ent_q;
      dest_d = dest_q;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q  <= '0;
      dest_q <= '0;
    end else begin
      ent_q  <= ent_d;
      dest_q <= dest_d;
    end
  end

`ifdef BYPASS_STATS_EN
  logic [31:0] fwd_count_q, fwd_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        fwd_evt_s, stall_evt_s;

  assign fwd_evt_s   = ~hold & issue_valid & ~stall_s & ((rs_sel != '0) | (rt_sel != '0));
  assign stall_evt_s = ~hold & stall_s;

  // Saturating event counters.
  always_comb begin
    if (fwd_evt_s && (fwd_count_q != 32'hFFFF_FFFF)) begin
      fwd_count_d = fwd_count_q + 32'd1;
    end else begin
      fwd_count_d = fwd_count_q;
    end
    if (stall_evt_s && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count_q   <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fwd_count_q   <= fwd_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_count   = fwd_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
